// File: rtl/voq_pkg.sv
// rtl/voq_pkg.sv - shared types for the VOQ round-robin scheduler
package voq_pkg;

  localparam int DEFAULT_NUM_VOQ = 4;
  localparam int DEFAULT_IDX_W   = $clog2(DEFAULT_NUM_VOQ);

  typedef logic [DEFAULT_IDX_W-1:0]   voq_idx_t;
  typedef logic [DEFAULT_NUM_VOQ-1:0] voq_mask_t;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } sched_state_t;

endpackage

// File: rtl/rr_priority_pick.sv
// rtl/rr_priority_pick.sv - combinational rotating priority encoder
module rr_priority_pick #(
  parameter int NUM_VOQ = 4,
  parameter int IDX_W   = $clog2(NUM_VOQ)
) (
  input  logic [NUM_VOQ-1:0] elig,
  input  logic [IDX_W-1:0]   start,
  output logic               found,
  output logic [IDX_W-1:0]   index
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_VOQ - 1);

  // Walk from start with an explicit wrap so non-power-of-two sizes never visit invalid indices.
  always_comb begin
    logic [IDX_W-1:0] cand;
    found = 1'b0;
    index = '0;
    cand  = start;
    for (int i = 0; i < NUM_VOQ; i++) begin
      if (!found && elig[cand]) begin
        found = 1'b1;
        index = cand;
      end
      cand = (cand == LAST) ? '0 : cand + IDX_W'(1);
    end
  end

endmodule

// File: rtl/voq_rr_scheduler.sv
// rtl/voq_rr_scheduler.sv - registered round-robin VOQ picker; optional VOQ_PICK_BURST_EN
module voq_rr_scheduler
  import voq_pkg::*;
#(
  parameter int NUM_VOQ   = DEFAULT_NUM_VOQ,
  parameter int IDX_W     = $clog2(NUM_VOQ),
  parameter int BURST_MAX = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_VOQ-1:0] voq_empty,
  input  logic [NUM_VOQ-1:0] voq_picked,
  input  logic               pick_req,
  input  logic               pick_accept,
  input  logic               pick_reject,
  output logic               pick_valid,
  output logic [IDX_W-1:0]   voq_to_pick,
  output logic               no_available_voq,
  output logic [IDX_W-1:0]   rr_ptr
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_VOQ - 1);

  sched_state_t       state, state_next;
  logic [NUM_VOQ-1:0] elig;
  logic               found;
  logic [IDX_W-1:0]   winner;
  logic               do_pick, do_accept, do_reject;
  logic [IDX_W-1:0]   ptr_adv, ptr_on_accept;

  assign elig = ~voq_empty & ~voq_picked;

  rr_priority_pick #(
    .NUM_VOQ (NUM_VOQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .elig  (elig),
    .start (rr_ptr),
    .found (found),
    .index (winner)
  );

  assign do_pick   = (state == IDLE) && pick_req;
  assign do_accept = (state == HOLD) && pick_accept;
  assign do_reject = (state == HOLD) && !pick_accept && pick_reject;
  assign ptr_adv   = (voq_to_pick == LAST) ? '0 : voq_to_pick + IDX_W'(1);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (do_pick && found) state_next = HOLD;
      HOLD:    if (do_accept || do_reject) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

`ifdef VOQ_PICK_BURST_EN
  localparam int CNT_W = $clog2(BURST_MAX + 1);

  logic [IDX_W-1:0] last_idx;
  logic [CNT_W-1:0] burst_cnt, cnt_inc;

  // Repeat winners keep priority until their run of accepts reaches BURST_MAX.
  always_comb begin
    cnt_inc       = (voq_to_pick == last_idx) ? burst_cnt + CNT_W'(1) : CNT_W'(1);
    ptr_on_accept = (cnt_inc == CNT_W'(BURST_MAX)) ? ptr_adv : voq_to_pick;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_idx  <= '0;
      burst_cnt <= '0;
    end else if (do_accept) begin
      last_idx  <= voq_to_pick;
      burst_cnt <= (cnt_inc == CNT_W'(BURST_MAX)) ? '0 : cnt_inc;
    end
  end
`else
  logic [31:0] unused_burst_max;
  assign unused_burst_max = 32'(BURST_MAX);
  assign ptr_on_accept    = ptr_adv;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pick_valid       <= 1'b0;
      voq_to_pick      <= '0;
      no_available_voq <= 1'b0;
      rr_ptr           <= '0;
    end else begin
      no_available_voq <= do_pick && !found;
      if (do_pick && found) begin
        pick_valid  <= 1'b1;
        voq_to_pick <= winner;
      end
      if (do_accept || do_reject) pick_valid <= 1'b0;
      if (do_accept) rr_ptr <= ptr_on_accept;
    end
  end

endmodule
